// File: rtl/regfile_seq_if.sv
// Request/response and LR-bus signal bundle between the execute logic, the
// regfile_seq sequencer and the BC/DE/HL register bank.
interface regfile_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_pair;
  logic        req_wide;
  logic        req_half;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic [1:0]  lr_sel;
  logic        l_oe;
  logic        r_oe;
  logic        l_wr;
  logic        r_wr;
  logic [15:0] lr_dout;
  logic        lr_drive;
  logic [15:0] lr_din;

  modport master (
    output req_valid, req_op, req_pair, req_wide, req_half, req_wdata, lr_din,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  lr_sel, l_oe, r_oe, l_wr, r_wr, lr_dout, lr_drive
  );

  modport slave (
    input  req_valid, req_op, req_pair, req_wide, req_half, req_wdata, lr_din,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output lr_sel, l_oe, r_oe, l_wr, r_wr, lr_dout, lr_drive
  );
endinterface

// File: rtl/regfile_seq.sv
// Micro-op sequencer for the BC/DE/HL register bank: turns READ/WRITE/INC/DEC
// requests into LR-port strobe sequences and returns a one-cycle response.
module regfile_seq (
  input logic         clk,
  input logic         rst,
  regfile_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_TA   = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_DEC   = 2'd3;
  localparam logic [1:0] PAIR_RSV = 2'd3;

  // Bus value -> operand, zero-extended into [7:0] for 8-bit ops.
  function automatic logic [15:0] lane_in(input logic [15:0] v, input logic wide, input logic half);
    if (wide) begin
      lane_in = v;
    end else if (half) begin
      lane_in = {8'h00, v[7:0]};
    end else begin
      lane_in = {8'h00, v[15:8]};
    end
  endfunction

  // Operand -> bus value, placing an 8-bit operand in its lane and zeroing the other.
  function automatic logic [15:0] lane_out(input logic [15:0] v, input logic wide, input logic half);
    if (wide) begin
      lane_out = v;
    end else if (half) begin
      lane_out = {8'h00, v[7:0]};
    end else begin
      lane_out = {v[7:0], 8'h00};
    end
  endfunction

  // 8-bit operands wrap within the lane; nothing carries into the upper byte.
  function automatic logic [15:0] inc_dec(input logic [15:0] v, input logic wide, input logic dec);
    if (wide) begin
      inc_dec = dec ? (v - 16'd1) : (v + 16'd1);
    end else begin
      inc_dec = {8'h00, (dec ? (v[7:0] - 8'd1) : (v[7:0] + 8'd1))};
    end
  endfunction

  state_t      r_state;
  logic [1:0]  r_op;
  logic [1:0]  r_pair;
  logic        r_wide;
  logic        r_half;
  logic [15:0] r_tmp;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [15:0] r_rsp_rdata;
  logic [1:0]  r_lr_sel;
  logic        r_l_oe;
  logic        r_r_oe;
  logic        r_l_wr;
  logic        r_r_wr;
  logic [15:0] r_lr_dout;
  logic        r_lr_drive;

  logic        w_accept;
  logic        w_new_l;
  logic        w_new_r;
  logic        w_aff_l;
  logic        w_aff_r;
  logic [15:0] w_tmp_next;
  logic [15:0] w_wr_word;

  assign w_accept   = bus.req_valid & r_req_ready;
  assign w_new_l    = bus.req_wide | ~bus.req_half;
  assign w_new_r    = bus.req_wide | bus.req_half;
  assign w_aff_l    = r_wide | ~r_half;
  assign w_aff_r    = r_wide | r_half;
  assign w_tmp_next = inc_dec(r_tmp, r_wide, (r_op == OP_DEC));
  assign w_wr_word  = lane_out(lane_in(bus.req_wdata, bus.req_wide, bus.req_half),
                               bus.req_wide, bus.req_half);

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.lr_sel    = r_lr_sel;
  assign bus.l_oe      = r_l_oe;
  assign bus.r_oe      = r_r_oe;
  assign bus.l_wr      = r_l_wr;
  assign bus.r_wr      = r_r_wr;
  assign bus.lr_dout   = r_lr_dout;
  assign bus.lr_drive  = r_lr_drive;

  // Sequencer FSM; every output is loaded with the value for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_op        <= 2'd0;
      r_pair      <= 2'd0;
      r_wide      <= 1'b0;
      r_half      <= 1'b0;
      r_tmp       <= 16'h0000;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 16'h0000;
      r_lr_sel    <= 2'd0;
      r_l_oe      <= 1'b0;
      r_r_oe      <= 1'b0;
      r_l_wr      <= 1'b0;
      r_r_wr      <= 1'b0;
      r_lr_dout   <= 16'h0000;
      r_lr_drive  <= 1'b0;
    end else begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 16'h0000;
      r_lr_sel    <= 2'd0;
      r_l_oe      <= 1'b0;
      r_r_oe      <= 1'b0;
      r_l_wr      <= 1'b0;
      r_r_wr      <= 1'b0;
      r_lr_dout   <= 16'h0000;
      r_lr_drive  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.req_op;
            r_pair <= bus.req_pair;
            r_wide <= bus.req_wide;
            r_half <= bus.req_half;
            if (bus.req_pair == PAIR_RSV) begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (bus.req_op == OP_WRITE) begin
              r_state    <= S_WR;
              r_lr_sel   <= bus.req_pair;
              r_lr_drive <= 1'b1;
              r_lr_dout  <= w_wr_word;
              r_l_wr     <= w_new_l;
              r_r_wr     <= w_new_r;
            end else begin
              r_state  <= S_RD;
              r_lr_sel <= bus.req_pair;
              r_l_oe   <= w_new_l;
              r_r_oe   <= w_new_r;
            end
          end else begin
            // Also the first edge after reset release, which raises ready.
            r_req_ready <= 1'b1;
          end
        end
        S_RD: begin
          r_tmp <= lane_in(bus.lr_din, r_wide, r_half);
          if (r_op == OP_READ) begin
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= lane_in(bus.lr_din, r_wide, r_half);
          end else begin
            r_state <= S_TA;
          end
        end
        S_TA: begin
          r_tmp      <= w_tmp_next;
          r_state    <= S_WR;
          r_lr_sel   <= r_pair;
          r_lr_drive <= 1'b1;
          r_lr_dout  <= lane_out(w_tmp_next, r_wide, r_half);
          r_l_wr     <= w_aff_l;
          r_r_wr     <= w_aff_r;
        end
        S_WR: begin
          r_state     <= S_RSP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= (r_op == OP_WRITE) ? 16'h0000 : r_tmp;
        end
        S_RSP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq: a behavioural register bank on the LR
// port, a directed vector table, reset-abort sequences and random ops.
module tb_regfile_seq;

  logic clk;
  logic rst;
  regfile_seq_if bus ();

  regfile_seq dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic [15:0] tb_bank  [0:3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] ref_bank [0:3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

  // Per-cycle trace of the most recent op (index = cycles after acceptance).
  logic [1:0]  tr_sel   [0:7];
  logic        tr_loe   [0:7];
  logic        tr_roe   [0:7];
  logic        tr_lwr   [0:7];
  logic        tr_rwr   [0:7];
  logic        tr_drv   [0:7];
  logic [15:0] tr_dout  [0:7];

  // The register bank as a device on the LR port.
  assign bus.lr_din = bus.lr_drive ? bus.lr_dout :
                      {(bus.l_oe ? tb_bank[bus.lr_sel][15:8] : 8'h00),
                       (bus.r_oe ? tb_bank[bus.lr_sel][7:0]  : 8'h00)};

  always @(posedge clk) begin
    if (bus.l_wr) tb_bank[bus.lr_sel][15:8] <= bus.lr_dout[15:8];
    if (bus.r_wr) tb_bank[bus.lr_sel][7:0]  <= bus.lr_dout[7:0];
  end

  always @(negedge clk) begin
    if (bus.lr_drive && (bus.l_oe || bus.r_oe)) viol <= viol + 1;
  end

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit bank_match();
    return (tb_bank[0] == ref_bank[0]) && (tb_bank[1] == ref_bank[1]) && (tb_bank[2] == ref_bank[2]);
  endfunction

  // Reference: applies one op to ref_bank and returns the expected response.
  task automatic ref_step(input logic [1:0] op, input logic [1:0] pair, input logic wide,
                          input logic half, input logic [15:0] wdata,
                          output logic [15:0] rd, output logic err);
    logic [15:0] old;
    int lane;
    int md;
    err = (pair == 2'd3);
    rd  = 16'h0000;
    if (!err) begin
      old  = ref_bank[pair];
      md   = wide ? 65536 : 256;
      lane = wide ? int'(old) : (half ? int'(old[7:0]) : int'(old[15:8]));
      case (op)
        2'd0: rd = 16'(lane);
        2'd1: lane = wide ? int'(wdata) : (half ? int'(wdata[7:0]) : int'(wdata[15:8]));
        2'd2: begin lane = (lane + 1) % md;      rd = 16'(lane); end
        default: begin lane = (lane + md - 1) % md; rd = 16'(lane); end
      endcase
      if (op != 2'd0) begin
        if (wide)      ref_bank[pair] = 16'(lane);
        else if (half) ref_bank[pair] = {old[15:8], 8'(lane)};
        else           ref_bank[pair] = {8'(lane), old[7:0]};
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] pair, input logic wide,
                       input logic half, input logic [15:0] wdata, input string nm);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(bus.req_ready == 1'b1, {nm, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_pair  = pair;
    bus.req_wide  = wide;
    bus.req_half  = half;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_pair  = 2'($urandom_range(0, 3));
    bus.req_wide  = 1'($urandom_range(0, 1));
    bus.req_half  = 1'($urandom_range(0, 1));
    bus.req_wdata = 16'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] pair, input logic wide,
                        input logic half, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input logic exp_err, input string nm);
    int lat, seen, extra, mm, ph;
    logic [15:0] got_rdata;
    logic got_err;
    logic aff_l, aff_r;
    lat   = (pair == 2'd3) ? 1 : ((op == 2'd0 || op == 2'd1) ? 2 : 4);
    aff_l = wide | ~half;
    aff_r = wide | half;
    seen = 0; extra = 0; mm = 0;
    got_rdata = 16'h0000; got_err = 1'b0;
    issue(op, pair, wide, half, wdata, nm);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tr_sel[c] = bus.lr_sel;  tr_loe[c] = bus.l_oe;  tr_roe[c] = bus.r_oe;
      tr_lwr[c] = bus.l_wr;    tr_rwr[c] = bus.r_wr;  tr_drv[c] = bus.lr_drive;
      tr_dout[c] = bus.lr_dout;
      if (bus.rsp_valid) begin
        if (seen == 0) begin
          seen = c; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
        end else begin
          extra++;
        end
      end
      // Phase per cycle: 0 none, 1 RD, 2 TA, 3 WR.
      ph = 0;
      if (pair != 2'd3) begin
        if (op == 2'd0 && c == 1) ph = 1;
        if (op == 2'd1 && c == 1) ph = 3;
        if (op[1] && c <= 3) ph = c;
      end
      if (tr_loe[c] != ((ph == 1) && aff_l)) mm++;
      if (tr_roe[c] != ((ph == 1) && aff_r)) mm++;
      if (tr_lwr[c] != ((ph == 3) && aff_l)) mm++;
      if (tr_rwr[c] != ((ph == 3) && aff_r)) mm++;
      if (tr_drv[c] != (ph == 3)) mm++;
      if ((ph == 1 || ph == 3) && tr_sel[c] != pair) mm++;
      if (ph == 3 && !wide && half && tr_dout[c][15:8] != 8'h00) mm++;
      if (ph == 3 && !wide && !half && tr_dout[c][7:0] != 8'h00) mm++;
    end
    check(seen == lat && extra == 0, {nm, " rsp latency"}, 32'(seen), 32'(lat));
    check(got_rdata == exp_rdata, {nm, " rsp_rdata"}, 32'(got_rdata), 32'(exp_rdata));
    check(got_err == exp_err, {nm, " rsp_err"}, 32'(got_err), 32'(exp_err));
    check(mm == 0, {nm, " strobes"}, 32'(mm), 32'd0);
    check(bank_match(), {nm, " bank"}, {tb_bank[pair[0] ? 1 : 0], 16'h0}, {ref_bank[pair[0] ? 1 : 0], 16'h0});
  endtask

  task automatic reset_mid(input logic [1:0] op, input logic [1:0] pair, input logic wide,
                           input logic half, input logic [15:0] wdata, input int at_cyc, input string nm);
    int pulses = 0;
    issue(op, pair, wide, half, wdata, nm);
    for (int c = 1; c <= at_cyc; c++) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check({bus.rsp_valid, bus.rsp_err, bus.l_oe, bus.r_oe, bus.l_wr, bus.r_wr, bus.lr_drive,
           bus.req_ready, bus.lr_sel, bus.lr_dout, bus.rsp_rdata} == 42'd0,
          {nm, " outputs in reset"}, {bus.lr_dout, 8'h00, bus.l_oe, bus.r_oe, bus.l_wr, bus.r_wr,
           bus.lr_drive, bus.rsp_valid, bus.req_ready, 1'b0}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    rst = 1'b1;
    @(negedge clk);
    check(bus.req_ready == 1'b1, {nm, " ready after release"}, 32'(bus.req_ready), 32'd1);
    if (bus.rsp_valid) pulses++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    check(pulses == 0, {nm, " no rsp"}, 32'(pulses), 32'd0);
    check(bank_match(), {nm, " bank"}, {tb_bank[pair[0] ? 1 : 2], 16'h0}, {ref_bank[pair[0] ? 1 : 2], 16'h0});
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  pair;
    logic        wide;
    logic        half;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [0:16];

  initial begin
    logic [15:0] m_rd;
    logic m_err;
    logic [1:0] r_op, r_pair;
    logic r_wide, r_half;
    logic [15:0] r_wd;
    int act;

    vt[0]  = '{2'd1, 2'd1, 1'b1, 1'b0, 16'hA55A, 16'h0000, 1'b0}; // WRITE DE
    vt[1]  = '{2'd0, 2'd1, 1'b1, 1'b0, 16'h0000, 16'hA55A, 1'b0}; // READ DE
    vt[2]  = '{2'd1, 2'd2, 1'b1, 1'b0, 16'h1200, 16'h0000, 1'b0}; // WRITE HL
    vt[3]  = '{2'd1, 2'd2, 1'b0, 1'b1, 16'hFF3C, 16'h0000, 1'b0}; // WRITE L reg
    vt[4]  = '{2'd0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h123C, 1'b0}; // READ HL
    vt[5]  = '{2'd1, 2'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0}; // WRITE BC
    vt[6]  = '{2'd2, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0}; // INC BC wraps
    vt[7]  = '{2'd0, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0}; // READ BC
    vt[8]  = '{2'd3, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h00FF, 1'b0}; // DEC B
    vt[9]  = '{2'd0, 2'd0, 1'b1, 1'b0, 16'h0000, 16'hFF00, 1'b0}; // READ BC
    vt[10] = '{2'd0, 2'd3, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1}; // reserved pair
    vt[11] = '{2'd2, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h0013, 1'b0}; // INC H
    vt[12] = '{2'd3, 2'd1, 1'b1, 1'b0, 16'h0000, 16'hA559, 1'b0}; // DEC DE
    vt[13] = '{2'd2, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0}; // INC B FF->00
    vt[14] = '{2'd0, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0}; // READ BC
    vt[15] = '{2'd0, 2'd1, 1'b0, 1'b1, 16'h0000, 16'h0059, 1'b0}; // READ E
    vt[16] = '{2'd1, 2'd3, 1'b0, 1'b1, 16'h7777, 16'h0000, 1'b1}; // reserved WRITE

    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_pair = 2'd0;
    bus.req_wide = 1'b0; bus.req_half = 1'b0; bus.req_wdata = 16'h0000;

    repeat (2) @(negedge clk);
    check({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.l_oe, bus.r_oe, bus.l_wr, bus.r_wr,
           bus.lr_drive, bus.lr_sel, bus.lr_dout, bus.rsp_rdata} == 42'd0, "reset outputs",
          {bus.lr_dout, 8'h00, bus.req_ready, bus.rsp_valid, bus.l_oe, bus.r_oe, bus.l_wr,
           bus.r_wr, bus.lr_drive, 1'b0}, 32'd0);
    rst = 1'b1;
    #1 check(bus.req_ready == 1'b0, "ready before first edge", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check(bus.req_ready == 1'b1, "ready first edge", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i <= 16; i++) begin
      ref_step(vt[i].op, vt[i].pair, vt[i].wide, vt[i].half, vt[i].wdata, m_rd, m_err);
      run_op(vt[i].op, vt[i].pair, vt[i].wide, vt[i].half, vt[i].wdata,
             vt[i].exp_rdata, vt[i].exp_err, $sformatf("vec%0d", i));
      case (i)
        0: begin
          check(tr_sel[1] == 2'd1 && tr_lwr[1] && tr_rwr[1], "DE write strobes",
                {tr_sel[1], tr_lwr[1], tr_rwr[1]}, 32'h7);
          check(tr_dout[1] == 16'hA55A, "DE write dout", 32'(tr_dout[1]), 32'hA55A);
        end
        3: check(tr_dout[1] == 16'h003C && !tr_lwr[1] && tr_rwr[1], "L reg write",
                 {tr_dout[1], 6'd0, tr_lwr[1], tr_rwr[1]}, 32'h003C_0001);
        6: check(tr_dout[3] == 16'h0000 && tr_drv[3] && tr_loe[1] && tr_roe[1] && !tr_drv[2],
                 "INC BC sequence", 32'(tr_dout[3]), 32'h0);
        8: begin
          check(tr_loe[1] && !tr_roe[1] && tr_lwr[3] && !tr_rwr[3], "DEC B strobes",
                {tr_loe[1], tr_roe[1], tr_lwr[3], tr_rwr[3]}, 32'ha);
          check(tr_dout[3][15:8] == 8'hFF, "DEC B dout", 32'(tr_dout[3]), 32'hFF00);
        end
        10: begin
          act = 0;
          for (int c = 1; c <= 6; c++)
            act += int'(tr_loe[c]) + int'(tr_roe[c]) + int'(tr_lwr[c]) + int'(tr_rwr[c]) + int'(tr_drv[c]);
          check(act == 0, "reserved pair activity", 32'(act), 32'd0);
        end
        default: ;
      endcase
    end

    reset_mid(2'd2, 2'd2, 1'b1, 1'b0, 16'h0000, 2, "rst in TA");
    reset_mid(2'd1, 2'd1, 1'b1, 1'b0, 16'h5555, 1, "rst in WR");

    for (int k = 0; k < 40; k++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_pair = 2'($urandom_range(0, 3));
      r_wide = 1'($urandom_range(0, 1));
      r_half = 1'($urandom_range(0, 1));
      r_wd   = 16'($urandom);
      ref_step(r_op, r_pair, r_wide, r_half, r_wd, m_rd, m_err);
      run_op(r_op, r_pair, r_wide, r_half, r_wd, m_rd, m_err, $sformatf("rand%0d", k));
    end

    check(viol == 0, "drive with oe", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_seq.md
# regfile_seq

Request-driven sequencer for the BC/DE/HL general-purpose register bank, on the controller side of the bank's LR port. It accepts one micro-op at a time from the decode/execute logic (READ, WRITE, INC, DEC on an 8-bit half or a 16-bit pair) and generates the bank's `lr_sel`, `l_wr/l_oe`, `r_wr/r_oe` strobes and LR bus drive. It then returns a one-cycle response. Tristating of the shared LR bus is done at the top level from `lr_drive`.

## Interface
- No parameters; the data width is fixed at 16 bits (L = [15:8], R = [7:0]).
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: a request is present.
- `req_ready` output 1: high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_op` input 2: 00 READ, 01 WRITE, 10 INC, 11 DEC.
- `req_pair` input 2: 00 BC, 01 DE, 10 HL, 11 reserved (error).
- `req_wide` input 1: 1 selects the 16-bit pair; 0 selects an 8-bit half.
- `req_half` input 1: used only when `req_wide=0`; 0 selects L (B/D/H), 1 selects R (C/E/L).
- `req_wdata` input 16: WRITE data; for 8-bit writes only the selected lane is used.
- `rsp_valid` output 1: one-cycle pulse at op completion; there is no backpressure.
- `rsp_err` output 1: valid with `rsp_valid`; 1 means a reserved pair was selected.
- `rsp_rdata` output 16: READ returns the value read; INC/DEC return the new value; WRITE returns 0. For 8-bit ops the value is zero-extended in [7:0].
- `lr_sel` output 2: pair select to the bank.
- `l_oe` output 1, `r_oe` output 1: L/R half output enables.
- `l_wr` output 1, `r_wr` output 1: L/R half write enables; the bank captures on the edge that ends the cycle.
- `lr_dout` output 16: data onto the LR bus.
- `lr_drive` output 1: enables the `lr_dout` drivers onto the LR bus.
- `lr_din` input 16: the LR bus as seen by the sequencer.

## Operation
- The FSM has the states IDLE, RD, TA, WR and RSP. All outputs are registered.
- The request fields are latched on acceptance.
  - The affected half set is: L only, R only, or both when wide.
  - For an 8-bit half the lane is [15:8] for L and [7:0] for R, on both `lr_dout` and `lr_din`.
- Transitions out of IDLE on acceptance:
  - A reserved pair goes directly to RSP with `rsp_err=1`. No strobes are issued.
  - READ goes to RD, then RSP.
  - WRITE goes to WR, then RSP.
  - INC and DEC go to RD, TA, WR, then RSP.
- RSP always returns to IDLE.
- RD state:
  - `lr_sel` = pair; the `*_oe` outputs are high for the affected halves only.
  - `lr_din` is captured into `tmp` at the edge ending RD.
- TA state: all `oe`, `wr` and `lr_drive` are low (bus turnaround). `tmp` is replaced by `tmp±1`:
  - wide ops use 16-bit modular arithmetic (FFFF+1=0000, 0000-1=FFFF);
  - 8-bit ops wrap within the lane (FF+1=00) with no carry into the other half.
- WR state:
  - `lr_sel` = pair; `lr_drive=1`.
  - `lr_dout` = `req_wdata` for WRITE, or `tmp` for INC/DEC.
  - The `*_wr` outputs are high for the affected halves only.
  - The unused lane of `lr_dout` is driven with 0.
- RSP state: `rsp_valid=1`, with `rsp_rdata` and `rsp_err` as defined in the Interface.
- Bus invariants:
  - no cycle ever has `lr_drive=1` together with `l_oe` or `r_oe`;
  - `*_wr` is never high outside WR;
  - `*_oe` is never high outside RD.
- While rst is low, all outputs are forced to 0 and the FSM is forced to IDLE.
- A reset asserted mid-operation:
  - aborts the operation immediately;
  - no `rsp_valid` is ever produced for the aborted request;
  - a partially completed INC/DEC leaves the bank unmodified, because WR was not reached.

## Timing
- Reset values: `req_ready=0`; `rsp_valid`, `rsp_err`, `rsp_rdata`, `lr_sel`, all `oe`/`wr`, `lr_dout` and `lr_drive` are 0.
- `req_ready` rises on the first edge after rst deasserts.
- Let edge 0 be the accepting edge:
  - READ: RD in cycle 1, `rsp_valid` in cycle 2, `req_ready` again in cycle 3.
  - WRITE: WR in cycle 1, `rsp_valid` in cycle 2.
  - INC/DEC: RD in cycle 1, TA in cycle 2, WR in cycle 3, `rsp_valid` in cycle 4.
  - Error: `rsp_valid` in cycle 1.
- `req_ready` drops in the cycle after acceptance and returns with IDLE.
- Throughput is 3 cycles per op for READ/WRITE and 5 cycles for INC/DEC.
- Changes on `req_*` while `req_ready=0` are ignored.

## Test plan
- WRITE pair DE with 16'hA55A, then READ DE wide.
  - Required: WR cycle has `lr_sel=01`, `l_wr=r_wr=1`, `lr_dout=A55A`.
  - Required: the read response has `rsp_rdata=A55A` at cycle 2 after acceptance.
- 8-bit WRITE of HL R-half (L register) with 8'h3C, bank holding 16'h1200.
  - Required: only `r_wr` pulses, with `lr_dout=003C`.
  - Required: a following wide READ returns 123C.
- INC of BC wide holding FFFF.
  - Required: sequence RD→TA→WR→RSP with `lr_dout=0000`, `rsp_rdata=0000` at cycle 4.
  - Required: no cycle has `lr_drive` and `oe` high together.
- DEC of the B half (BC L-half) with BC=0000.
  - Required: only `l_oe`, then only `l_wr`, with `lr_dout[15:8]=FF`.
  - Required: C is unchanged and `rsp_rdata=00FF`.
- Request with `req_pair=11`.
  - Required: `rsp_valid` with `rsp_err=1` at cycle 1, and no `oe`/`wr`/`lr_drive` activity at all.
- Reset pulse asserted during the TA state of an INC.
  - Required: all strobes go to 0 immediately and no `rsp_valid` is produced.
  - Required: `req_ready` goes high on the first edge after release, and the bank value is unchanged.
